// File: rtl/matrix_load_sequencer.sv
// matrix_load_sequencer: takes the eight 2x2 operand elements (A00..A11, then
// B00..B11) one per valid/ready handshake and turns each one into a registered
// index/strobe/data write for the element-select decoder. It pulses load_done
// in the same cycle as the 8th write.
// Optional build macro TRANSPOSE_B_EN: B arrives column-major, so the middle
// two B slots are swapped (element 5 -> reg 6, element 6 -> reg 5).
module matrix_load_sequencer #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [IDX_W-1:0]  sel,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              load_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic                load_done_q, load_done_d;
  logic                accept;

  // Element-order to register-index mapping.
  function automatic logic [IDX_W-1:0] map_idx(input logic [IDX_W-1:0] c);
`ifdef TRANSPOSE_B_EN
    case (c)
      IDX_W'(5): map_idx = IDX_W'(6);
      IDX_W'(6): map_idx = IDX_W'(5);
      default:   map_idx = c;
    endcase
`else
    map_idx = c;
`endif
  endfunction

  // Ready is a pure decode of state, so it drops asynchronously with reset.
  assign in_ready = (state_q == LOAD);
  assign accept   = in_valid & in_ready & ~abort;

  // Next-state and next-output logic; abort has priority over an offered element.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    load_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          sel_d     = map_idx(cnt_q);
          wr_data_d = in_data;
          wr_en_d   = 1'b1;
          cnt_d     = cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(7)) begin
            state_d     = DONE;
            load_done_d = 1'b1;
          end
        end
      end
      DONE: begin
        // Single cycle; load_done and the 8th wr_en are both high here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; everything clears asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      load_done_q <= load_done_d;
    end
  end

  assign sel       = sel_q;
  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign load_done = load_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Directed bench for matrix_load_sequencer with hand-computed expectations.
module tb_matrix_load_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, in_valid;
  logic [7:0] in_data;
  logic       in_ready, wr_en, busy, load_done;
  logic [2:0] sel;
  logic [7:0] wr_data;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_sel [8];

  matrix_load_sequencer #(.DATA_W(8), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sel(sel), .wr_en(wr_en), .wr_data(wr_data), .busy(busy),
    .load_done(load_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Offer one element for one cycle and check the write that follows.
  task automatic put(input logic [7:0] d, input int idx, input logic last);
    in_valid = 1'b1; in_data = d;
    chk("rdy_before_accept", in_ready, 1);
    step();
    chk("wr_en", wr_en, 1);
    chk("sel", sel, exp_sel[idx]);
    chk("wr_data", wr_data, d);
    chk("load_done", load_done, last);
  endtask

  initial begin
`ifdef TRANSPOSE_B_EN
    exp_sel = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7};
`else
    exp_sel = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
    rst_n = 1'b0; start = 0; abort = 0; in_valid = 0; in_data = 0;
    #12;
    chk("rst_sel", sel, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_rdy", in_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("idle_rdy", in_ready, 0);
    abort = 1'b1; step(); abort = 1'b0;
    chk("idle_abort_busy", busy, 0);

    // Back-to-back load; start pulsed mid-load; 9th valid held afterwards.
    start = 1'b1; step(); start = 1'b0;
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      start = (i == 3);
      put(8'((i + 1) * 8'h11), i, i == 7);
    end
    start = 1'b0;
    in_data = 8'h99;  // in_valid still 1
    chk("done_rdy", in_ready, 0);
    chk("done_busy", busy, 1);
    abort = 1'b1;     // ignored in DONE
    step(); abort = 1'b0;
    chk("post_wr_en", wr_en, 0);
    chk("post_done", load_done, 0);
    chk("post_busy", busy, 0);
    chk("post_rdy", in_ready, 0);
    step();
    chk("post2_wr_en", wr_en, 0);
    chk("post2_done", load_done, 0);
    chk("post2_sel_hold", sel, exp_sel[7]);
    in_valid = 1'b0;

    // Gapped valid: writes hold through gaps, counter continues at 3.
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(8'(8'h05 + i), i, 1'b0);
      in_valid = 1'b0;
      for (int g = 0; g < 2; g++) begin
        step();
        chk("gap_wr_en", wr_en, 0);
        chk("gap_sel_hold", sel, exp_sel[i]);
        chk("gap_data_hold", wr_data, 8'(8'h05 + i));
        chk("gap_busy", busy, 1);
      end
    end
    for (int i = 3; i < 8; i++) put(8'(8'hA0 + i), i, i == 7);
    in_valid = 1'b0;
    step();
    chk("gap_end_busy", busy, 0);

    // Abort together with the 4th element.
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) put(8'((i + 1) * 8'h11), i, 1'b0);
    in_valid = 1'b1; in_data = 8'h44; abort = 1'b1;
    step();
    in_valid = 1'b0; abort = 1'b0;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_sel", sel, exp_sel[2]);
    chk("abort_data", wr_data, 8'h33);
    chk("abort_busy", busy, 0);
    chk("abort_rdy", in_ready, 0);
    chk("abort_done", load_done, 0);
    step();
    chk("abort2_done", load_done, 0);
    start = 1'b1; step(); start = 1'b0;
    put(8'h55, 0, 1'b0);
    in_valid = 1'b0;

    // Asynchronous reset in the middle of a load.
    for (int i = 1; i < 5; i++) put(8'(8'h60 + i), i, 1'b0);
    chk("pre_rst_wr_en", wr_en, 1);
    #2 rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("arst_wr_en", wr_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rdy", in_ready, 0);
    chk("arst_sel", sel, 0);
    @(negedge clk); rst_n = 1'b1;
    step();
    start = 1'b1; step(); start = 1'b0;
    put(8'h77, 0, 1'b0);
    in_valid = 1'b0;

    // Mapping sequence with 0xA0..0xA7.
    abort = 1'b1; step(); abort = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 8; i++) put(8'(8'hA0 + i), i, i == 7);
    in_valid = 1'b0;
    step();
    chk("map_end_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/matrix_load_sequencer.md
Name: matrix_load_sequencer

Overview:
- Sits directly upstream of the 3-to-8 element-select decoder in the 2x2 matrix multiplier.
- Accepts eight operand elements serially over a valid/ready handshake: A00, A01, A10, A11, B00, B01, B10, B11.
- For each element, drives the 3-bit register index to the decoder, together with a write strobe and write data.
- Pulses load_done after the 8th write so the compute stage can start.

Parameters:
- DATA_W, 8, width of one matrix element.
- IDX_W, 3, width of the register index driven to the decoder (fixed at 3; 8 elements).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- abort  input  1  cancels an in-progress load.
- in_valid  input  1  upstream element valid.
- in_data  input  DATA_W  upstream element value.
- in_ready  output  1  sequencer can accept an element this cycle.
- sel  output  IDX_W  register index to decoder input.
- wr_en  output  1  write strobe qualifying the decoder output.
- wr_data  output  DATA_W  data for the selected register.
- busy  output  1  high in LOAD and DONE.
- load_done  output  1  one-cycle pulse after the 8th write.

Behaviour:
- Reset (asynchronous on rst_n low; release is synchronous to clk):
  - State goes to IDLE and cnt to 0.
  - sel=0, wr_en=0, wr_data=0, busy=0, load_done=0, in_ready=0.
- States: IDLE, LOAD, DONE. cnt is a 3-bit element counter.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD with cnt=0.
  - abort in IDLE is ignored.
- LOAD:
  - in_ready=1 combinationally. Acceptance = in_valid & in_ready & ~abort.
  - On acceptance: register sel<=map(cnt), wr_data<=in_data, wr_en<=1, cnt<=cnt+1.
  - Write appears exactly 1 cycle after the acceptance edge. wr_en is a single-cycle pulse per accepted element.
  - No acceptance: wr_en<=0; sel and wr_data hold their last values.
  - Acceptance with cnt=7 -> DONE. cnt wraps to 0. No 9th element is accepted; in_ready drops in DONE.
  - Back-to-back valid gives 8 writes in 8 consecutive cycles.
  - start while in LOAD or DONE is ignored.
- DONE (exactly 1 cycle):
  - load_done=1 (registered). This cycle coincides with wr_en for the 8th element being high, and the compute stage samples after it.
  - in_ready=0.
  - Next state is IDLE.
- abort:
  - abort=1 in LOAD -> IDLE, cnt<=0, wr_en<=0, no load_done. Elements already written remain written.
  - abort and in_valid in the same cycle: abort wins and that element is not written.
  - abort in DONE is ignored; load_done still pulses.
- Reset mid-load: all outputs drop immediately (asynchronous), and the partial load is discarded from the sequencer's view.
- busy = (state != IDLE).
- Default map(cnt) = cnt.

Optional Feature:
- Macro TRANSPOSE_B_EN.
- Defined: B is delivered column-major. map(4)=4, map(5)=6, map(6)=5, map(7)=7. map is identity for 0..3.
- Undefined: map is identity for all cnt, and B is row-major like A.
- Handshake, latency and load_done timing are identical in both builds.

Test Plan:
- Reset then start; 8 back-to-back elements 0x11..0x88:
  - in_ready is 1 in cycles 1..8.
  - sel = 0,1,...,7 with wr_data = 0x11..0x88, each 1 cycle after acceptance.
  - load_done pulses once in the cycle of the 8th write; then IDLE with busy=0.
- Gapped valid (elements 0x05, 0x06, 0x07 with 2 idle cycles between): wr_en is high exactly 3 cycles; sel and wr_data hold during gaps; cnt=3.
- Abort after 3 accepts, with abort and in_valid both 1 on the 4th element 0x44:
  - No write of 0x44, no load_done, state IDLE.
  - A new start then begins at sel=0.
- start asserted during LOAD, and a 9th in_valid held after the 8th accept: both ignored; exactly 8 wr_en pulses and 1 load_done.
- rst_n low mid-load (after 5 elements): wr_en, busy and in_ready go 0 without waiting for a clk edge; next start restarts at sel=0.
- TRANSPOSE_B_EN build, elements 0xA0..0xA7: sel sequence is 0,1,2,3,4,6,5,7. Without the macro, the same stimulus gives 0..7.
